// File: rtl/des_input_buffer.sv
// Byte-to-64-bit block assembler feeding the DES controller.
// Define DES_INPUT_BUFFER_PAD_EN to zero-pad partial blocks instead of dropping them.
module des_input_buffer #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic        flush,
    input  logic        block_taken,
    output logic        receive,
    output logic [63:0] block_data,
    output logic [2:0]  pad_len,
    output logic        drop
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        PAD     = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [2:0]  cnt;
    logic [2:0]  slot;
    logic [3:0]  fill;
    logic        accept;
    logic        last_byte;
    logic        flush_hit;

    assign accept    = rx_ready && rx_valid;
    assign slot      = MSB_FIRST ? ~cnt : cnt;
    assign fill      = {1'b0, cnt} + {3'b000, accept};
    assign last_byte = accept && (cnt == 3'd7);
    assign flush_hit = (state == COLLECT) && flush &&
                       !last_byte && (fill != 4'd0);

    // state register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= COLLECT;
        end else begin
            state <= state_nx;
        end
    end

    // next-state logic; a completing byte wins over a same-cycle flush
    always_comb begin
        state_nx = state;
        unique case (state)
            COLLECT: begin
                if (last_byte) begin
                    state_nx = HOLD;
                end else if (flush_hit) begin
`ifdef DES_INPUT_BUFFER_PAD_EN
                    state_nx = PAD;
`else
                    state_nx = COLLECT;
`endif
                end
            end
            PAD: begin
                if (cnt == 3'd7) begin
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (block_taken) begin
                    state_nx = COLLECT;
                end
            end
            default: state_nx = COLLECT;
        endcase
    end

    // handshake outputs decoded from the current state
    always_comb begin
        rx_ready = (state == COLLECT);
        receive  = (state == HOLD);
    end

    // byte counter, block assembly, pad length and drop pulse
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt        <= 3'd0;
            block_data <= 64'd0;
            pad_len    <= 3'd0;
            drop       <= 1'b0;
        end else begin
            drop <= 1'b0;
            unique case (state)
                COLLECT: begin
                    if (accept) begin
                        block_data[{slot, 3'b000} +: 8] <= rx_data;
                        cnt <= cnt + 3'd1;
                    end
                    if (flush_hit) begin
`ifdef DES_INPUT_BUFFER_PAD_EN
                        // 8 - fill modulo 8, fill is 1..7 here
                        pad_len <= 3'd0 - fill[2:0];
`else
                        cnt        <= 3'd0;
                        block_data <= 64'd0;
                        drop       <= 1'b1;
`endif
                    end
                end
                PAD: begin
                    block_data[{slot, 3'b000} +: 8] <= 8'd0;
                    cnt <= cnt + 3'd1;
                end
                HOLD: begin
                    // clear so the next partial block starts from zero
                    if (block_taken) begin
                        block_data <= 64'd0;
                        pad_len    <= 3'd0;
                    end
                end
                default: begin
                    cnt <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_des_input_buffer.sv
// Randomized self-checking bench for des_input_buffer.
// Runs MSB_FIRST=1 and MSB_FIRST=0 instances side by side.
module tb_des_input_buffer;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        flush = 1'b0;
    logic        block_taken = 1'b0;

    logic        rdy_m, rcv_m, drop_m;
    logic [63:0] data_m;
    logic [2:0]  pad_m;
    logic        rdy_l, rcv_l, drop_l;
    logic [63:0] data_l;
    logic [2:0]  pad_l;

    int checks = 0;
    int failures = 0;

    logic [7:0] q[$];

    des_input_buffer #(.MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .n_rst(n_rst), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rdy_m), .flush(flush),
        .block_taken(block_taken), .receive(rcv_m),
        .block_data(data_m), .pad_len(pad_m), .drop(drop_m)
    );

    des_input_buffer #(.MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .n_rst(n_rst), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rdy_l), .flush(flush),
        .block_taken(block_taken), .receive(rcv_l),
        .block_data(data_l), .pad_len(pad_l), .drop(drop_l)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // expected block: byte i of the stream, zeros beyond the queue
    function automatic logic [63:0] exp_blk(input bit msb);
        logic [63:0] r;
        r = 64'd0;
        for (int i = 0; i < q.size() && i < 8; i++) begin
            if (msb) r[63 - 8*i -: 8] = q[i];
            else     r[8*i +: 8] = q[i];
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        q.push_back(b);
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic take();
        rx_valid    = 1'b0;
        flush       = 1'b0;
        block_taken = 1'b1;
        tick();
        block_taken = 1'b0;
        q.delete();
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        #12;
        checks++;
        if ({rcv_m, rcv_l, drop_m, drop_l, pad_m, pad_l} !== 10'd0 ||
            data_m !== 64'd0 || data_l !== 64'd0) begin
            failures++;
            $display("FAIL reset_outputs rcv=%b drop=%b pad=%0d data=%h want 0",
                     rcv_m, drop_m, pad_m, data_m);
        end
        @(negedge clk);
        n_rst = 1'b1;
        tick();
        checks++;
        if ({rdy_m, rdy_l} !== 2'b11) begin
            failures++;
            $display("FAIL reset_ready got=%b%b want 11", rdy_m, rdy_l);
        end
    endtask

    task automatic test_full_block();
        q.delete();
        for (int i = 1; i <= 8; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'(i);
            q.push_back(8'(i));
            tick();
            if (i == 7) begin
                checks++;
                if (rcv_m !== 1'b0) begin
                    failures++;
                    $display("FAIL full_early_rcv got=%b want 0", rcv_m);
                end
            end
        end
        rx_valid = 1'b0;
        checks++;
        if (rcv_m !== 1'b1 || rcv_l !== 1'b1 ||
            data_m !== 64'h0102030405060708 || pad_m !== 3'd0 ||
            rdy_m !== 1'b0) begin
            failures++;
            $display("FAIL full_msb rcv=%b data=%h pad=%0d rdy=%b want 1 0102030405060708 0 0",
                     rcv_m, data_m, pad_m, rdy_m);
        end
        checks++;
        if (data_l !== 64'h0807060504030201) begin
            failures++;
            $display("FAIL full_lsb got=%h want 0807060504030201", data_l);
        end
        take();
        checks++;
        if ({rdy_m, rcv_m, pad_m} !== 5'b10_000) begin
            failures++;
            $display("FAIL full_release rdy=%b rcv=%b pad=%0d want 1 0 0",
                     rdy_m, rcv_m, pad_m);
        end
    endtask

    task automatic test_hold_stall();
        logic [63:0] held;
        q.delete();
        for (int i = 0; i < 8; i++) send(8'($urandom));
        held = exp_blk(1'b1);
        rx_valid = 1'b1;
        rx_data  = 8'hAA;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (rdy_m !== 1'b0 || rcv_m !== 1'b1 || data_m !== held) begin
                failures++;
                $display("FAIL hold_stall cyc=%0d rdy=%b rcv=%b data=%h want 0 1 %h",
                         i, rdy_m, rcv_m, data_m, held);
            end
        end
        block_taken = 1'b1;
        tick();
        block_taken = 1'b0;
        q.delete();
        checks++;
        if (rdy_m !== 1'b1 || rcv_m !== 1'b0) begin
            failures++;
            $display("FAIL hold_release rdy=%b rcv=%b want 1 0", rdy_m, rcv_m);
        end
        q.push_back(8'hAA);
        tick();
        for (int i = 0; i < 7; i++) send(8'($urandom));
        checks++;
        if (rcv_m !== 1'b1 || data_m !== exp_blk(1'b1) ||
            data_m[63:56] !== 8'hAA || data_l !== exp_blk(1'b0)) begin
            failures++;
            $display("FAIL hold_next_block got=%h want %h", data_m, exp_blk(1'b1));
        end
        take();
    endtask

    task automatic test_partial();
        q.delete();
        send(8'h11);
        send(8'h22);
        send(8'h33);
        flush = 1'b1;
        tick();
        flush = 1'b0;
`ifdef DES_INPUT_BUFFER_PAD_EN
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rcv_m !== 1'b0 || rdy_m !== 1'b0 || drop_m !== 1'b0) begin
                failures++;
                $display("FAIL pad_busy cyc=%0d rcv=%b rdy=%b drop=%b want 0 0 0",
                         i, rcv_m, rdy_m, drop_m);
            end
            tick();
        end
        tick();
        checks++;
        if (rcv_m !== 1'b1 || data_m !== 64'h1122330000000000 ||
            pad_m !== 3'd5 || drop_m !== 1'b0) begin
            failures++;
            $display("FAIL pad_done rcv=%b data=%h pad=%0d want 1 1122330000000000 5",
                     rcv_m, data_m, pad_m);
        end
        checks++;
        if (data_l !== 64'h0000000000332211 || pad_l !== 3'd5) begin
            failures++;
            $display("FAIL pad_done_lsb data=%h pad=%0d want 0000000000332211 5",
                     data_l, pad_l);
        end
        take();
`else
        checks++;
        if (drop_m !== 1'b1 || drop_l !== 1'b1 || rcv_m !== 1'b0 ||
            rdy_m !== 1'b1 || data_m !== 64'd0 || pad_m !== 3'd0) begin
            failures++;
            $display("FAIL drop_pulse drop=%b rcv=%b rdy=%b data=%h want 1 0 1 0",
                     drop_m, rcv_m, rdy_m, data_m);
        end
        q.delete();
        tick();
        checks++;
        if (drop_m !== 1'b0 || rcv_m !== 1'b0) begin
            failures++;
            $display("FAIL drop_end drop=%b rcv=%b want 0 0", drop_m, rcv_m);
        end
        for (int i = 0; i < 8; i++) send(8'($urandom));
        checks++;
        if (rcv_m !== 1'b1 || data_m !== exp_blk(1'b1)) begin
            failures++;
            $display("FAIL drop_restart got=%h want %h", data_m, exp_blk(1'b1));
        end
        take();
`endif
    endtask

    task automatic test_flush_last();
        q.delete();
        for (int i = 0; i < 7; i++) send(8'($urandom));
        rx_valid = 1'b1;
        rx_data  = 8'h88;
        flush    = 1'b1;
        q.push_back(8'h88);
        tick();
        rx_valid = 1'b0;
        flush    = 1'b0;
        checks++;
        if (rcv_m !== 1'b1 || pad_m !== 3'd0 || drop_m !== 1'b0 ||
            data_m !== exp_blk(1'b1) || data_l !== exp_blk(1'b0)) begin
            failures++;
            $display("FAIL flush_last rcv=%b pad=%0d drop=%b data=%h want 1 0 0 %h",
                     rcv_m, pad_m, drop_m, data_m, exp_blk(1'b1));
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (rcv_m !== 1'b1 || drop_m !== 1'b0 || pad_m !== 3'd0) begin
            failures++;
            $display("FAIL flush_in_hold rcv=%b drop=%b pad=%0d want 1 0 0",
                     rcv_m, drop_m, pad_m);
        end
        take();
    endtask

    task automatic test_reset_mid();
        q.delete();
        for (int i = 0; i < 4; i++) send(8'($urandom | 8'h01));
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        checks++;
        if (data_m !== 64'd0 || data_l !== 64'd0 || rcv_m !== 1'b0 ||
            drop_m !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid data=%h rcv=%b drop=%b want 0", data_m,
                     rcv_m, drop_m);
        end
        @(negedge clk);
        n_rst = 1'b1;
        tick();
        q.delete();
        for (int i = 0; i < 8; i++) send(8'hF0 + 8'(i));
        checks++;
        if (rcv_m !== 1'b1 || data_m !== 64'hF0F1F2F3F4F5F6F7 ||
            data_l !== 64'hF7F6F5F4F3F2F1F0 || drop_m !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_block got=%h want F0F1F2F3F4F5F6F7", data_m);
        end
        take();
    endtask

    task automatic test_ignored();
        q.delete();
        block_taken = 1'b1;
        flush       = 1'b1;
        tick();
        block_taken = 1'b0;
        flush       = 1'b0;
        checks++;
        if (drop_m !== 1'b0 || rcv_m !== 1'b0 || rdy_m !== 1'b1 ||
            pad_m !== 3'd0) begin
            failures++;
            $display("FAIL idle_flush drop=%b rcv=%b rdy=%b pad=%0d want 0 0 1 0",
                     drop_m, rcv_m, rdy_m, pad_m);
        end
        for (int i = 0; i < 3; i++) send(8'($urandom));
        block_taken = 1'b1;
        tick();
        block_taken = 1'b0;
        for (int i = 0; i < 5; i++) send(8'($urandom));
        checks++;
        if (rcv_m !== 1'b1 || data_m !== exp_blk(1'b1)) begin
            failures++;
            $display("FAIL stray_taken got=%h want %h", data_m, exp_blk(1'b1));
        end
        take();
    endtask

    task automatic test_random();
        bit done;
        bit v;
        bit f;
        for (int blk = 0; blk < 40; blk++) begin
            q.delete();
            done = 1'b0;
            for (int cyc = 0; cyc < 200 && !done; cyc++) begin
                v = ($urandom % 4) != 0;
                f = ($urandom % 8) == 0;
                checks++;
                if (rdy_m !== 1'b1 || rdy_l !== 1'b1) begin
                    failures++;
                    $display("FAIL rnd_ready blk=%0d got=%b want 1", blk, rdy_m);
                end
                rx_valid = v;
                rx_data  = 8'($urandom);
                flush    = f;
                if (v) q.push_back(rx_data);
                tick();
                rx_valid = 1'b0;
                flush    = 1'b0;
                if (q.size() == 8) begin
                    checks++;
                    if ({rcv_m, rcv_l} !== 2'b11 || pad_m !== 3'd0 ||
                        drop_m !== 1'b0 || data_m !== exp_blk(1'b1) ||
                        data_l !== exp_blk(1'b0)) begin
                        failures++;
                        $display("FAIL rnd_full blk=%0d got=%h want %h",
                                 blk, data_m, exp_blk(1'b1));
                    end
                    done = 1'b1;
                end else if (f && q.size() > 0) begin
`ifdef DES_INPUT_BUFFER_PAD_EN
                    for (int p = 0; p < 7 - q.size(); p++) begin
                        checks++;
                        if (rcv_m !== 1'b0 || rdy_m !== 1'b0) begin
                            failures++;
                            $display("FAIL rnd_pad_busy blk=%0d rcv=%b rdy=%b want 0 0",
                                     blk, rcv_m, rdy_m);
                        end
                        tick();
                    end
                    tick();
                    checks++;
                    if (rcv_m !== 1'b1 || data_m !== exp_blk(1'b1) ||
                        data_l !== exp_blk(1'b0) ||
                        pad_m !== 3'(8 - q.size()) || pad_l !== pad_m) begin
                        failures++;
                        $display("FAIL rnd_pad blk=%0d data=%h pad=%0d want %h %0d",
                                 blk, data_m, pad_m, exp_blk(1'b1), 8 - q.size());
                    end
                    done = 1'b1;
`else
                    checks++;
                    if ({drop_m, drop_l} !== 2'b11 || rcv_m !== 1'b0 ||
                        data_m !== 64'd0 || pad_l !== 3'd0) begin
                        failures++;
                        $display("FAIL rnd_drop blk=%0d drop=%b data=%h want 1 0",
                                 blk, drop_m, data_m);
                    end
                    q.delete();
`endif
                end else begin
                    checks++;
                    if (drop_m !== 1'b0 || rcv_m !== 1'b0) begin
                        failures++;
                        $display("FAIL rnd_collect blk=%0d drop=%b rcv=%b want 0 0",
                                 blk, drop_m, rcv_m);
                    end
                end
            end
            if (!done) begin
                failures++;
                $display("FAIL rnd_budget blk=%0d no block completed", blk);
            end else begin
                for (int h = 0; h < int'($urandom % 4); h++) begin
                    rx_valid = 1'($urandom);
                    rx_data  = 8'($urandom);
                    tick();
                    checks++;
                    if (rdy_m !== 1'b0 || rcv_m !== 1'b1) begin
                        failures++;
                        $display("FAIL rnd_hold blk=%0d rdy=%b rcv=%b want 0 1",
                                 blk, rdy_m, rcv_m);
                    end
                end
                take();
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_block();
        test_hold_stall();
        test_partial();
        test_flush_last();
        test_reset_mid();
        test_ignored();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
